// File: rtl/wall_cfg_pkg.sv
// ---------------------------------------------------------------------------
// wall_cfg_pkg
// Shared types and constants for the wall configuration sequencer.
//   wus_state_t   : sequencer state (IDLE / ARMED / COPY)
//   wall_field_t  : renderer field selector (x0, x1, y0, y1)
//   ctrl_addr()   : CPU address of the control word for N walls
//   CTRL_*_BIT    : bit positions inside the control word
// ---------------------------------------------------------------------------
package wall_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COPY  = 2'd2
  } wus_state_t;

  typedef enum logic [1:0] {
    F_X0 = 2'd0,
    F_X1 = 2'd1,
    F_Y0 = 2'd2,
    F_Y1 = 2'd3
  } wall_field_t;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_CLR_BIT    = 1;

  // The control word sits directly after the 4*N shadow words.
  function automatic int ctrl_addr(input int n);
    return 4 * n;
  endfunction

endpackage

// File: rtl/wall_shadow_regfile.sv
// ---------------------------------------------------------------------------
// wall_shadow_regfile
// Shadow bank of DEPTH x WIDTH coordinate registers.
//   clk, rst_n  : clock, asynchronous active-low clear of every word
//   i_wr_en     : write strobe
//   i_wr_addr   : write word index
//   i_wr_data   : write data
//   i_rd_addr   : read word index
//   o_rd_data   : combinational read data
// ---------------------------------------------------------------------------
module wall_shadow_regfile #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 11,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_word [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_word[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_word[i_wr_addr] <= i_wr_data;
    end
  end

  // Combinational read: the copy engine snapshots each word as it is replayed.
  assign o_rd_data = r_word[i_rd_addr];

endmodule

// File: rtl/wall_update_scheduler.sv
// ---------------------------------------------------------------------------
// wall_update_scheduler
// Buffers CPU stores of wall rectangles in a shadow bank and, once a commit
// is armed, replays the whole bank into the renderer write port during the
// next vertical blanking interval, one word per cycle.
//   clk, rst_n     : clock, asynchronous active-low reset
//   we_i           : CPU store strobe
//   addr_i         : {wall, field} for 0..4N-1, 4N = control word
//   data_i         : store data (control: bit0 commit, bit1 clear flags)
//   vblank_i       : vertical blanking level, synchronous to clk
//   wall_we_o      : renderer write strobe
//   wall_sel_o     : target wall index
//   wall_field_o   : target field (x0, x1, y0, y1)
//   wall_data_o    : coordinate, zero-extended
//   pending_o      : commit armed, waiting for a vblank rise
//   busy_o         : replay in progress
//   drop_o         : sticky, a CPU store hit the bank during replay
//   overrun_o      : sticky, vblank ended before replay finished
// ---------------------------------------------------------------------------
module wall_update_scheduler
  import wall_cfg_pkg::*;
#(
  parameter int N       = 2,
  parameter int COORD_W = 11,
  parameter int ADDR_W  = $clog2(4*N+1),
  parameter int SEL_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  input  logic              vblank_i,
  output logic              wall_we_o,
  output logic [SEL_W-1:0]  wall_sel_o,
  output logic [1:0]        wall_field_o,
  output logic [31:0]       wall_data_o,
  output logic              pending_o,
  output logic              busy_o,
  output logic              drop_o,
  output logic              overrun_o
);

  localparam int WORDS = 4 * N;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(ctrl_addr(N));
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS - 1);

  wus_state_t         r_state;
  wus_state_t         w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_next;
  logic               r_rearm;
  logic               w_rearm_next;
  logic               r_vblank_q;
  logic               r_drop;
  logic               r_overrun;

  logic               w_rise;
  logic               w_fall;
  logic               w_addr_shadow;
  logic               w_ctrl_wr;
  logic               w_commit;
  logic               w_clear;
  logic               w_copying;
  logic               w_shadow_wr;
  logic               w_store_dropped;
  logic [COORD_W-1:0] w_rd_data;
  logic [SEL_W-1:0]   w_idx_sel;
  wall_field_t        w_field;

  // Upper data bits carry no coordinate information.
  logic w_unused_data;
  assign w_unused_data = ^data_i[31:COORD_W];

  assign w_rise = vblank_i & ~r_vblank_q;
  assign w_fall = ~vblank_i & r_vblank_q;

  // Addresses above the control word fall through both decodes and are ignored.
  assign w_addr_shadow = (addr_i < CTRL_ADDR);
  assign w_ctrl_wr     = we_i & (addr_i == CTRL_ADDR);
  assign w_commit      = w_ctrl_wr & data_i[CTRL_COMMIT_BIT];
  assign w_clear       = w_ctrl_wr & data_i[CTRL_CLR_BIT];

  // Blocking stores while copying keeps the replayed set coherent.
  assign w_copying       = (r_state == COPY);
  assign w_shadow_wr     = we_i & w_addr_shadow & ~w_copying;
  assign w_store_dropped = we_i & w_addr_shadow & w_copying;

  wall_shadow_regfile #(
    .DEPTH (WORDS),
    .WIDTH (COORD_W),
    .AW    (IDX_W)
  ) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_shadow_wr),
    .i_wr_addr (addr_i[IDX_W-1:0]),
    .i_wr_data (data_i[COORD_W-1:0]),
    .i_rd_addr (r_idx),
    .o_rd_data (w_rd_data)
  );

  // Replay index splits into {wall, field}; a single wall has no select bits.
  generate
    if (N > 1) begin : g_sel_multi
      assign w_idx_sel = r_idx[IDX_W-1:2];
    end else begin : g_sel_single
      assign w_idx_sel = '0;
    end
  endgenerate

  assign w_field = wall_field_t'(r_idx[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_rearm    <= 1'b0;
      r_vblank_q <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_rearm    <= w_rearm_next;
      r_vblank_q <= vblank_i;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_rearm_next = r_rearm;
    wall_we_o    = 1'b0;
    wall_sel_o   = '0;
    wall_field_o = '0;
    wall_data_o  = '0;
    case (r_state)
      IDLE: begin
        if (w_commit) begin
          w_state_next = ARMED;
        end
      end
      ARMED: begin
        // Commits here are redundant; only a vblank rise matters.
        if (w_rise) begin
          w_state_next = COPY;
          w_idx_next   = '0;
          w_rearm_next = 1'b0;
        end
      end
      COPY: begin
        wall_we_o    = 1'b1;
        wall_sel_o   = w_idx_sel;
        wall_field_o = w_field;
        wall_data_o  = 32'(w_rd_data);
        // A commit mid-replay is remembered and re-arms for the next frame.
        if (w_commit) begin
          w_rearm_next = 1'b1;
        end
        if (r_idx == LAST_IDX) begin
          w_state_next = (r_rearm | w_commit) ? ARMED : IDLE;
          w_idx_next   = '0;
          w_rearm_next = 1'b0;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Clear is applied before any set from the same cycle, so a coincident
  // event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_drop    <= (r_drop & ~w_clear) | w_store_dropped;
      r_overrun <= (r_overrun & ~w_clear) | (w_copying & w_fall);
    end
  end

  assign busy_o    = w_copying;
  assign pending_o = (r_state == ARMED);
  assign drop_o    = r_drop;
  assign overrun_o = r_overrun;

endmodule

// File: tb/tb_wall_update_scheduler.sv
// ---------------------------------------------------------------------------
// tb_wall_update_scheduler
// Directed scenarios with literal expectations, followed by randomized
// traffic, all checked every cycle against a queue-based behavioural model.
// ---------------------------------------------------------------------------
module tb_wall_update_scheduler;

  logic        clk;
  logic        rst_n;
  logic        we_i;
  logic [3:0]  addr_i;
  logic [31:0] data_i;
  logic        vblank_i;
  logic        wall_we_o;
  logic [0:0]  wall_sel_o;
  logic [1:0]  wall_field_o;
  logic [31:0] wall_data_o;
  logic        pending_o;
  logic        busy_o;
  logic        drop_o;
  logic        overrun_o;

  wall_update_scheduler #(.N(2), .COORD_W(11)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .data_i       (data_i),
    .vblank_i     (vblank_i),
    .wall_we_o    (wall_we_o),
    .wall_sel_o   (wall_sel_o),
    .wall_field_o (wall_field_o),
    .wall_data_o  (wall_data_o),
    .pending_o    (pending_o),
    .busy_o       (busy_o),
    .drop_o       (drop_o),
    .overrun_o    (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        sel;
    logic [1:0]  field;
    logic [31:0] data;
  } wr_t;

  wr_t        mq[$];       // renderer writes still to be issued
  logic [10:0] m_sh [8];
  bit m_pend, m_rearm, m_drop, m_ovr, m_vbq;
  bit t_copying, t_rise, t_fall, t_commit, t_clr;
  wr_t t_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      for (int w = 0; w < 8; w++) m_sh[w] = '0;
      m_pend = 0; m_rearm = 0; m_drop = 0; m_ovr = 0; m_vbq = 0;
    end else begin
      t_copying = (mq.size() != 0);
      t_rise    = vblank_i && !m_vbq;
      t_fall    = !vblank_i && m_vbq;
      t_commit  = we_i && (addr_i == 4'd8) && data_i[0];
      t_clr     = we_i && (addr_i == 4'd8) && data_i[1];
      if (t_clr) begin
        m_drop = 0;
        m_ovr  = 0;
      end
      if (we_i && addr_i < 4'd8) begin
        if (t_copying) m_drop = 1;
        else m_sh[addr_i[2:0]] = data_i[10:0];
      end
      if (t_copying && t_fall) m_ovr = 1;
      if (t_copying) begin
        void'(mq.pop_front());
        if (t_commit) m_rearm = 1;
        if (mq.size() == 0) begin
          m_pend  = m_rearm;
          m_rearm = 0;
        end
      end else if (m_pend) begin
        if (t_rise) begin
          m_pend = 0;
          for (int w = 0; w < 8; w++) begin
            t_e.sel   = (w >= 4);
            t_e.field = 2'(w % 4);
            t_e.data  = 32'(m_sh[w]);
            mq.push_back(t_e);
          end
        end
      end else if (t_commit) begin
        m_pend = 1;
      end
      m_vbq = vblank_i;
    end
  end

  function automatic logic [39:0] act_vec();
    return {wall_we_o, wall_sel_o, wall_field_o, wall_data_o, pending_o, busy_o, drop_o, overrun_o};
  endfunction

  function automatic logic [39:0] exp_vec();
    wr_t e;
    bit  w;
    w = (mq.size() != 0);
    e = w ? mq[0] : '0;
    return {w, e.sel, e.field, e.data, m_pend, w, m_drop, m_ovr};
  endfunction

  // Renderer writes observed from the DUT, for directed literal checks.
  wr_t cap[$];

  always @(negedge clk) begin
    if (rst_n) begin
      check("cycle_outputs", 64'(act_vec()), 64'(exp_vec()));
      if (wall_we_o) cap.push_back({wall_sel_o, wall_field_o, wall_data_o});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic we, input logic [3:0] addr, input logic [31:0] data, input logic vb);
    @(negedge clk);
    #1;
    we_i = we; addr_i = addr; data_i = data; vblank_i = vb;
  endtask

  logic [31:0] ref_data [8];

  task automatic check_cap();
    check("cap_len", 64'(cap.size()), 64'd8);
    for (int i = 0; i < 8 && i < cap.size(); i++) begin
      check($sformatf("cap%0d", i), 64'(cap[i]), 64'({(i >= 4), 2'(i % 4), ref_data[i]}));
    end
  endtask

  initial begin
    ref_data = '{32'd22, 32'd60, 32'd35, 32'd200, 32'd1, 32'd2, 32'd3, 32'd4};
    rst_n = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0; vblank_i = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    check("reset_outputs", 64'(act_vec()), 64'd0);

    // Idle with vblank toggling: no renderer traffic.
    cap.delete();
    for (int i = 0; i < 10; i++) tick(1'b0, 4'd0, 32'd0, i[1]);
    tick(1'b0, 4'd0, 32'd0, 1'b0);
    check("idle_no_writes", 64'(cap.size()), 64'd0);
    check("idle_outputs", 64'(act_vec()), 64'd0);

    // Load bank, commit, then replay on the vblank rise.
    for (int i = 0; i < 8; i++) tick(1'b1, 4'(i), ref_data[i], 1'b0);
    tick(1'b1, 4'd8, 32'd1, 1'b0);
    tick(1'b0, 4'd0, 32'd0, 1'b0);
    check("armed_pending", 64'({pending_o, busy_o, wall_we_o}), 64'b100);
    cap.delete();
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    check("pending_before_rise", 64'({pending_o, wall_we_o}), 64'b10);
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    check("first_write", 64'({wall_we_o, busy_o, pending_o, wall_sel_o, wall_field_o, wall_data_o}),
          64'({1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd22}));
    repeat (9) tick(1'b0, 4'd0, 32'd0, 1'b1);
    check_cap();
    check("after_copy_idle", 64'({pending_o, busy_o}), 64'd0);

    // Store during third copy cycle is dropped.
    tick(1'b1, 4'd8, 32'd1, 1'b0);
    tick(1'b0, 4'd0, 32'd0, 1'b0);
    cap.delete();
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    tick(1'b1, 4'd1, 32'd99, 1'b1);
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    check("drop_set", 64'(drop_o), 64'd1);
    repeat (8) tick(1'b0, 4'd0, 32'd0, 1'b1);
    check_cap();
    tick(1'b1, 4'd8, 32'd2, 1'b1);
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    check("drop_cleared", 64'(drop_o), 64'd0);

    // Commit during copy re-arms; next rise replays again.
    tick(1'b1, 4'd8, 32'd1, 1'b0);
    tick(1'b0, 4'd0, 32'd0, 1'b0);
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    tick(1'b1, 4'd8, 32'd1, 1'b1);
    repeat (8) tick(1'b0, 4'd0, 32'd0, 1'b1);
    check("rearmed", 64'({pending_o, busy_o}), 64'b10);
    cap.delete();
    tick(1'b0, 4'd0, 32'd0, 1'b0);
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    repeat (10) tick(1'b0, 4'd0, 32'd0, 1'b1);
    check_cap();
    check("no_overrun", 64'(overrun_o), 64'd0);

    // vblank falls mid-copy: copy completes, overrun sticks.
    tick(1'b1, 4'd8, 32'd1, 1'b0);
    tick(1'b0, 4'd0, 32'd0, 1'b0);
    cap.delete();
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    tick(1'b0, 4'd0, 32'd0, 1'b0);
    repeat (8) tick(1'b0, 4'd0, 32'd0, 1'b0);
    check_cap();
    check("overrun_set", 64'(overrun_o), 64'd1);
    tick(1'b1, 4'd8, 32'd2, 1'b0);
    tick(1'b0, 4'd0, 32'd0, 1'b0);
    check("overrun_cleared", 64'(overrun_o), 64'd0);

    // Truncation, out-of-range store, async reset mid-copy.
    tick(1'b1, 4'd0, 32'hFFFF_F805, 1'b0);
    tick(1'b1, 4'd9, 32'h0000_0123, 1'b0);
    tick(1'b1, 4'd8, 32'd1, 1'b0);
    tick(1'b0, 4'd0, 32'd0, 1'b0);
    check("addr9_no_flags", 64'({drop_o, overrun_o, pending_o}), 64'b001);
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    check("truncated_data", 64'({wall_we_o, wall_data_o}), 64'({1'b1, 32'h0000_0005}));
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    tick(1'b0, 4'd0, 32'd0, 1'b1);
    check("mid_copy", 64'(wall_we_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset", 64'(act_vec()), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    check("post_reset", 64'(act_vec()), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic        we;
      logic [3:0]  addr;
      logic [31:0] data;
      we   = ($urandom_range(0, 1) == 1);
      addr = ($urandom_range(0, 5) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      data = $urandom();
      if ($urandom_range(0, 24) == 0) vblank_i = ~vblank_i;
      tick(we, addr, data, vblank_i);
    end
    tick(1'b0, 4'd0, 32'd0, 1'b0);
    tick(1'b0, 4'd0, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
